// File: rtl/cic_comp_pkg.sv
// rtl/cic_comp_pkg.sv - shared constants, coefficient table and FSM states for the CIC compensation FIR
package cic_comp_pkg;

    localparam int TAPS   = 7;
    localparam int COEF_W = 10;
    localparam int ACC_W  = 21;
    localparam int SHIFT  = 7;
    localparam int IDX_W  = 3;

    // Symmetric droop-compensation kernel; sums to 2^SHIFT for unity DC gain.
    localparam logic signed [COEF_W-1:0] COEFS [TAPS] = '{
        -10'sd8, 10'sd24, -10'sd64, 10'sd224, -10'sd64, 10'sd24, -10'sd8
    };

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

endpackage

// File: rtl/sat_round_8.sv
// rtl/sat_round_8.sv - round-half-up, arithmetic shift and clamp of an accumulator to signed 8 bits
import cic_comp_pkg::*;

module sat_round_8 (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [7:0]       y
);

    localparam logic signed [ACC_W:0] ROUND = (ACC_W+1)'(1) << (SHIFT-1);
    localparam logic signed [ACC_W:0] MAXV  = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] MINV  = (ACC_W+1)'(-128);

    logic signed [ACC_W:0] rounded;
    logic signed [ACC_W:0] shifted;

    // One guard bit keeps the rounding add from wrapping at the accumulator's extremes.
    always_comb begin
        rounded = (ACC_W+1)'(acc) + ROUND;
        shifted = rounded >>> SHIFT;
        if (shifted > MAXV) begin
            y = 8'sd127;
        end else if (shifted < MINV) begin
            y = -8'sd128;
        end else begin
            y = shifted[7:0];
        end
    end

endmodule

// File: rtl/cic_comp_fir.sv
// rtl/cic_comp_fir.sv - 7-tap droop-compensation FIR behind the CIC decimator, one shared MAC
import cic_comp_pkg::*;

module cic_comp_fir (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [7:0] d_in,
    input  logic              d_clk,
    output logic signed [7:0] d_out,
    output logic              d_valid,
    output logic              overrun
);

    state_t state;
    state_t next_state;

    logic                        d_clk_q;
    logic                        strobe;
    logic                        load;
    logic                        mac_en;
    logic                        out_en;
    logic                        busy_strobe;
    logic signed [7:0]           x [TAPS];
    logic        [IDX_W-1:0]     idx;
    logic signed [ACC_W-1:0]     acc;
    logic signed [7:0]           x_sel;
    logic signed [COEF_W-1:0]    coef_sel;
    logic signed [7+COEF_W:0]    prod;
    logic signed [7:0]           rounded;

    assign strobe = d_clk & ~d_clk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (strobe) next_state = MAC;
            MAC:     if (idx == IDX_W'(TAPS-1)) next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load        = (state == IDLE) && strobe;
        mac_en      = (state == MAC);
        out_en      = (state == OUT);
        busy_strobe = (state != IDLE) && strobe;
    end

    always_comb begin
        x_sel    = x[idx];
        coef_sel = COEFS[idx];
        prod     = x_sel * coef_sel;
    end

    sat_round_8 u_sat_round_8 (
        .acc (acc),
        .y   (rounded)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_clk_q <= 1'b0;
            d_out   <= '0;
            d_valid <= 1'b0;
            overrun <= 1'b0;
            acc     <= '0;
            idx     <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x[i] <= '0;
            end
        end else begin
            d_clk_q <= d_clk;
            d_valid <= out_en;
            if (load) begin
                for (int i = TAPS-1; i > 0; i--) begin
                    x[i] <= x[i-1];
                end
                x[0] <= d_in;
                acc  <= '0;
                idx  <= '0;
            end
            if (mac_en) begin
                acc <= acc + ACC_W'(prod);
                idx <= idx + 1'b1;
            end
            if (out_en) begin
                d_out <= rounded;
            end
            // Strobes landing mid-computation are lost; flag it until reset.
            if (busy_strobe) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cic_comp_fir.sv
// tb/tb_cic_comp_fir.sv - scoreboard bench for cic_comp_fir using directed hand-computed vectors
module tb_cic_comp_fir;

    logic              clk;
    logic              rst;
    logic signed [7:0] d_in;
    logic              d_clk;
    logic signed [7:0] d_out;
    logic              d_valid;
    logic              overrun;

    typedef struct {
        int v;
        int cyc;
    } exp_t;

    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_valid = 1'b0;

    int imp_exp [8]  = '{-4, 12, -32, 112, -32, 12, -4, 0};
    int p100_exp [7] = '{-6, 19, -50, 127, -50, 19, -6};
    int n100_exp [7] = '{6, -19, 50, -128, 50, -19, 6};
    int dc10_exp [7] = '{-1, 1, -4, 14, 9, 11, 10};
    int dcm_exp [7]  = '{19, -7, 62, -128, -111, -128, -128};
    int flush_exp [7] = '{-128, -112, -128, 48, -16, 8, 0};
    int ov_exp [7]   = '{-4, 12, -32, 112, -32, 12, -4};

    cic_comp_fir dut (
        .clk     (clk),
        .rst     (rst),
        .d_in    (d_in),
        .d_clk   (d_clk),
        .d_out   (d_out),
        .d_valid (d_valid),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && d_valid) begin
            if (prev_valid) begin
                checks++;
                failures++;
                $display("FAIL valid_back_to_back cyc=%0d got two consecutive d_valid, required isolated pulse", cyc);
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid cyc=%0d d_out=%0d, required no output", cyc, d_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (int'(d_out) != e.v || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL sample d_out=%0d at cyc=%0d, required %0d at cyc=%0d",
                             d_out, cyc, e.v, e.cyc);
                end
            end
        end
        prev_valid = d_valid;
    end

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%b required=%b", name, got, req);
        end
    endtask

    task automatic check_val(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    // Entered on a negedge; strobe edge is the following posedge.
    task automatic issue(input int v, input int hold, input int gap, input bit accepted, input int e);
        d_in  = 8'(v);
        d_clk = 1'b1;
        if (accepted) sb.push_back('{e, cyc + 9});
        repeat (hold) @(negedge clk);
        d_clk = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        d_in  = '0;
        d_clk = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_d_out", int'(d_out), 0);
        check_bit("reset_d_valid", d_valid, 1'b0);
        check_bit("reset_overrun", overrun, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) issue((i == 0) ? 64 : 0, 1, 15, 1'b1, imp_exp[i]);
        for (int i = 0; i < 7; i++) issue((i == 0) ? 100 : 0, 1, 15, 1'b1, p100_exp[i]);
        for (int i = 0; i < 7; i++) issue((i == 0) ? -100 : 0, 1, 15, 1'b1, n100_exp[i]);
        for (int i = 0; i < 20; i++) issue(10, 1, 11, 1'b1, (i < 7) ? dc10_exp[i] : 10);
        for (int i = 0; i < 10; i++) issue(-128, 1, 11, 1'b1, (i < 7) ? dcm_exp[i] : -128);
        for (int i = 0; i < 7; i++) issue(0, 1, 11, 1'b1, flush_exp[i]);
        check_bit("overrun_before", overrun, 1'b0);

        for (int i = 0; i < 14; i++) begin
            if (i % 2 == 0) issue((i == 0) ? 64 : 0, 1, 4, 1'b1, ov_exp[i/2]);
            else            issue(50, 1, 4, 1'b0, 0);
        end
        repeat (15) @(negedge clk);
        check_bit("overrun_set", overrun, 1'b1);

        issue(64, 40, 15, 1'b1, -4);
        check_bit("overrun_sticky", overrun, 1'b1);
        check_val("held_high_drained", sb.size(), 0);

        d_in  = 8'sd100;
        d_clk = 1'b1;
        @(negedge clk);
        d_clk = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("midrst_d_out", int'(d_out), 0);
        check_bit("midrst_d_valid", d_valid, 1'b0);
        check_bit("midrst_overrun", overrun, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(64, 1, 15, 1'b1, -4);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        check_val("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cic_comp_fir.md
Name: cic_comp_fir

Overview:
Compensation FIR placed directly downstream of the CIC decimator. It consumes the decimator's 8-bit output sample and its output-rate strobe. It flattens the CIC passband droop with a fixed 7-tap symmetric filter, using a single time-multiplexed multiply-accumulate. One rounded, saturated 8-bit sample is produced per input sample, with a one-cycle valid pulse.

Parameters:
- TAPS, 7, number of filter taps; must match the coefficient table length in the package.
- COEF_W, 10, signed coefficient width.
- ACC_W, 21, accumulator width = 8 + COEF_W + ceil(log2(TAPS)).
- SHIFT, 7, output scaling shift; the coefficient sum is 2^SHIFT, giving unity DC gain.

Ports:
- clk  input  1  system clock, same clock as the decimator.
- rst  input  1  reset, asynchronous, active-high.
- d_in  input  8  signed sample from the decimator (its d_out).
- d_clk  input  1  decimator output-rate clock/strobe, synchronous to clk; a new sample is present when a rising edge is seen.
- d_out  output  8  signed filtered sample.
- d_valid  output  1  one-cycle pulse when d_out updates.
- overrun  output  1  sticky flag; a strobe arrived while the filter was busy.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - All outputs are 0: d_out = 0, d_valid = 0, overrun = 0.
  - Delay line, accumulator, tap index and d_clk_q are all 0.
  - State = IDLE.
- Strobe detection: d_clk_q is d_clk registered. strobe = d_clk & ~d_clk_q. Only the rising edge counts; a held-high d_clk gives one strobe.
- Coefficients (package constant, index 0..6): -8, 24, -64, 224, -64, 24, -8. The sum is 128.
- States: IDLE, MAC, OUT.
  - IDLE, on an edge with strobe=1:
    - Shift the delay line: x[6..1] <= x[5..0], x[0] <= d_in.
    - acc <= 0, idx <= 0, go to MAC.
  - MAC: each edge does acc <= acc + x[idx]*h[idx] and idx <= idx+1. After the TAPS-th product, go to OUT.
  - OUT: one edge does d_out <= sat8((acc + 2^(SHIFT-1)) >>> SHIFT), d_valid <= 1, go to IDLE.
- Latency: a strobe seen at edge k gives d_valid high for exactly one cycle following edge k+TAPS+1 (k+8 at default). d_out holds its value until the next update.
- Arithmetic:
  - Signed multiply: 8 x COEF_W.
  - Full-precision accumulation in ACC_W bits; no overflow is possible at default coefficients.
  - Rounding is round-half-up: add 64, then arithmetic shift right.
  - Saturation clamps to [-128, 127].
- Busy strobe: a strobe in MAC or OUT, including the OUT edge itself, is dropped. The delay line is untouched and overrun <= 1, cleared only by rst. The minimum strobe spacing is TAPS+2 = 9 clocks, so the decimation ratio must be ≥ 9.
- Reset mid-operation: state returns to IDLE at once and the partial result is discarded. No d_valid is emitted for the interrupted sample.
- d_valid is never high on two consecutive cycles.

Decomposition:
- Package cic_comp_pkg holds:
  - localparam TAPS, COEF_W, ACC_W, SHIFT;
  - the coefficient array constant;
  - the state enum typedef (IDLE/MAC/OUT).
- Sub-module sat_round_8 (combinational): takes the ACC_W accumulator, adds the rounding constant, shifts, and clamps to 8 bits. It is shared with future downstream gain stages.

Test Plan:
- Reset: assert rst asynchronously mid-MAC, between clock edges -> d_out=0, d_valid=0 and overrun=0 immediately; no d_valid after release until a new strobe.
- Impulse: d_in=64 on one strobe, then 0, strobes every 16 clocks -> d_out sequence -4, 12, -32, 112, -32, 12, -4, 0. Each d_valid arrives exactly 8 edges after its strobe edge.
- Saturation and rounding: impulse d_in=100 -> sequence -6, 19, -50, 127 (saturated from 175), -50, 19, -6.
- Negative saturation: impulse d_in=-100 -> -6 becomes 6? No, exact sequence is 6, -19, 50, -128 (clamped), 50, -19, 6.
- DC: d_in=10 held for 20 strobes -> d_out settles to 10 from the 7th output onward. d_in=-128 held -> settles to -128.
- Overrun: strobes spaced 5 clocks apart -> every second strobe is dropped, overrun=1 and stays 1. Outputs match filtering of the accepted samples only. A d_clk held high for 40 clocks gives exactly one d_valid.
